// File: rtl/blit_pkg.sv
// Shared types and geometry for the sprite blitter.
package blit_pkg;
  localparam int unsigned FB_W    = 640;
  localparam int unsigned FB_H    = 480;
  localparam int unsigned SPR_W   = 20;
  localparam int unsigned SPR_H   = 20;
  localparam int unsigned NUM_SPR = 7;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned SUM_W   = 11;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned SPR_AW  = 12;
  localparam int unsigned FB_AW   = 19;
  localparam int unsigned PIX_W   = 24;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [FB_AW-1:0] fb_addr_t;

  localparam pixel_t KEY_COLOR = 24'hFF00FF;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} blit_state_t;
endpackage

// File: rtl/blit_addr_gen.sv
// Row/col walker for one sprite; registers ROM/frame-buffer addresses and clip flag
// from the next counter values so they line up with the FSM's next state.
module blit_addr_gen
  import blit_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [ID_W-1:0]    sprite_id,
  output logic [SPR_AW-1:0]  spr_addr,
  output fb_addr_t           fb_addr,
  output logic               in_bounds,
  output logic               last
);
  logic [CNT_W-1:0]   row, col, row_n, col_n;
  logic [COORD_W-1:0] px, py, px_n, py_n;
  logic [ID_W-1:0]    id, id_n;
  logic [SUM_W-1:0]   x_sum, y_sum;

  // Next counters; sums are 11 bits so off-screen positions never wrap back on.
  always_comb begin
    row_n = row;
    col_n = col;
    px_n  = px;
    py_n  = py;
    id_n  = id;
    if (load) begin
      row_n = '0;
      col_n = '0;
      px_n  = pos_x;
      py_n  = pos_y;
      id_n  = sprite_id;
    end else if (advance) begin
      if (col == CNT_W'(SPR_W - 1)) begin
        col_n = '0;
        row_n = row + CNT_W'(1);
      end else begin
        col_n = col + CNT_W'(1);
      end
    end
    x_sum = SUM_W'(px_n) + SUM_W'(col_n);
    y_sum = SUM_W'(py_n) + SUM_W'(row_n);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      row       <= '0;
      col       <= '0;
      px        <= '0;
      py        <= '0;
      id        <= '0;
      spr_addr  <= '0;
      fb_addr   <= '0;
      in_bounds <= 1'b0;
      last      <= 1'b0;
    end else begin
      row       <= row_n;
      col       <= col_n;
      px        <= px_n;
      py        <= py_n;
      id        <= id_n;
      spr_addr  <= SPR_AW'(id_n) * SPR_AW'(SPR_W * SPR_H)
                 + SPR_AW'(row_n) * SPR_AW'(SPR_W) + SPR_AW'(col_n);
      // y*640 as (y<<9)+(y<<7)
      fb_addr   <= (FB_AW'(y_sum) << 9) + (FB_AW'(y_sum) << 7) + FB_AW'(x_sum);
      in_bounds <= (x_sum < SUM_W'(FB_W)) && (y_sum < SUM_W'(FB_H));
      last      <= (row_n == CNT_W'(SPR_H - 1)) && (col_n == CNT_W'(SPR_W - 1));
    end
  end
endmodule

// File: rtl/sprite_blitter.sv
// Copies one 20x20 sprite from ROM into the frame buffer with off-screen clipping.
// Define SPRITE_BLITTER_TRANSPARENCY_EN to skip KEY_COLOR pixels.
module sprite_blitter
  import blit_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [ID_W-1:0]    sprite_id,
  output logic               busy,
  output logic               done,
  output logic [SPR_AW-1:0]  spr_addr,
  input  pixel_t             spr_data,
  output fb_addr_t           fb_addr,
  output pixel_t             fb_data,
  output logic               fb_we,
  input  logic               fb_ready
);
  blit_state_t state, state_n;
  logic load, advance, last, in_bounds, key_hit, write_ok;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign key_hit = (spr_data == KEY_COLOR);
`else
  assign key_hit = 1'b0;
`endif

  assign write_ok = in_bounds && !key_hit;

  blit_addr_gen u_addr_gen (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (load),
    .advance   (advance),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .sprite_id (sprite_id),
    .spr_addr  (spr_addr),
    .fb_addr   (fb_addr),
    .in_bounds (in_bounds),
    .last      (last)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  // ROM data arrives during WRITE, so the write port is decoded from it directly.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    advance = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    fb_we   = 1'b0;
    fb_data = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (sprite_id < ID_W'(NUM_SPR)) begin
            load    = 1'b1;
            state_n = READ;
          end else begin
            state_n = DONE;
          end
        end
      end
      READ: begin
        busy    = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        fb_data = spr_data;
        fb_we   = write_ok;
        advance = !write_ok || fb_ready;
        if (advance) state_n = last ? DONE : READ;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
